// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states and
// the illegal-op decode used by both the arbiter and the ALU.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_SLL    = 3'b100;
    localparam logic [2:0] ALU_SRL    = 3'b101;
    localparam logic [2:0] ALU_ILL_LO = 3'b110;
    localparam logic [2:0] ALU_ILL_HI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_is_illegal(input logic [2:0] ctrl);
        return (ctrl == ALU_ILL_LO) || (ctrl == ALU_ILL_HI);
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: add, sub, and, or, logical shifts.
// Unused op codes yield zero; the caller decides how to flag them.
module alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        ctrl,
    input  logic [4:0]        shiftamount,
    output logic              zero,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shiftamount;
            ALU_SRL: result = a >> shiftamount;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters; registered
// operands, registered tagged response with valid/ready, completion counter.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*3-1:0]      req_ctrl,
    input  logic [NREQ*5-1:0]      req_shamt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_err,
    output logic [15:0]            ops_done
);

    state_t              state_q, state_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]          op_ctrl_q, op_ctrl_d;
    logic [4:0]          op_shamt_q, op_shamt_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_err_q, rsp_err_d;
    logic [15:0]         ops_done_q, ops_done_d;

    logic                grant_any;
    logic [IDW-1:0]      grant_idx;
    logic [IDW-1:0]      cand;
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [2:0]          sel_ctrl;
    logic [4:0]          sel_shamt;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                op_illegal;

    // Rotating priority: the requester just after the last winner goes first.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && cand == IDW'(i) && req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_ctrl  = '0;
        sel_shamt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a     = req_a[DATA_W*i +: DATA_W];
                sel_b     = req_b[DATA_W*i +: DATA_W];
                sel_ctrl  = req_ctrl[3*i +: 3];
                sel_shamt = req_shamt[5*i +: 5];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_any) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    alu u_alu (
        .a           (op_a_q),
        .b           (op_b_q),
        .ctrl        (op_ctrl_q),
        .shiftamount (op_shamt_q),
        .zero        (alu_zero),
        .result      (alu_result)
    );

    assign op_illegal = op_is_illegal(op_ctrl_q);

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        op_shamt_d   = op_shamt_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    last_grant_d = grant_idx;
                    op_a_d       = sel_a;
                    op_b_d       = sel_b;
                    op_ctrl_d    = sel_ctrl;
                    op_shamt_d   = sel_shamt;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d     = last_grant_q;
                rsp_err_d    = op_illegal;
                rsp_result_d = op_illegal ? '0 : alu_result;
                rsp_zero_d   = op_illegal ? 1'b1 : alu_zero;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (ops_done_q != 16'hFFFF) begin
                        ops_done_d = ops_done_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            op_shamt_q   <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            op_shamt_q   <= op_shamt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign ops_done   = ops_done_q;

endmodule
